cla_acc_seq: RTL
================

Name: cla_acc_seq

Overview:
- Sequential accumulator controller placed directly around the 15-bit carry-lookahead add/subtract datapath.
- Upstream role: accepts commands over a valid/ready interface and drives the adder operands (A, B, mode).
- Downstream role: captures the adder's combinational sum, carry-out and overflow into an accumulator register, then presents the result over a second valid/ready interface.
- The adder stays external and combinational; this block owns all state.

Parameters:
- WIDTH, 15, operand/accumulator width; must match the adder width.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  0=CLEAR, 1=LOAD, 2=ADD, 3=SUB
- cmd_data  in  WIDTH  operand (ignored for CLEAR)
- add_a  out  WIDTH  adder operand A
- add_b  out  WIDTH  adder operand B
- add_mode  out  1  adder mode, 0=add, 1=subtract
- add_s  in  WIDTH  adder sum
- add_cout  in  1  adder carry-out
- add_ovf  in  1  adder signed overflow
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_acc  out  WIDTH  accumulator value
- res_cout  out  1  carry flag of the last operation
- res_ovf  out  1  overflow flag of the last operation
- ovf_sticky  out  1  sticky overflow since last clear
- sticky_clr  in  1  clears ovf_sticky

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: acc=0, res_cout=0, res_ovf=0, ovf_sticky=0, res_valid=0, state=IDLE, cmd_ready=1, op_q=0, data_q=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch op_q<=cmd_op, data_q<=cmd_data; go to EXEC.
- EXEC (exactly one cycle):
  - cmd_ready=0.
  - Drive add_a=acc, add_b=data_q, add_mode=(op_q==SUB).
  - At the end of the cycle, update per op:
    - CLEAR: acc<=0, cout<=0, ovf<=0.
    - LOAD: acc<=data_q, cout<=0, ovf<=0.
    - ADD/SUB: acc<=add_s, cout<=add_cout, ovf<=add_ovf.
  - Go to RESP.
- RESP:
  - res_valid=1; res_acc/res_cout/res_ovf stay stable while res_valid is high.
  - Hold until res_ready; on res_valid&res_ready go to IDLE.
  - res_ready asserted while not in RESP is ignored.
- Latency: command accepted at edge N; res_valid is high during the cycle after edge N+1; RESP exits at the first edge with res_ready high.
- Throughput: at most one command per 3 cycles; no overlap.
- Adder drive outside EXEC: add_a=acc, add_b=0, add_mode=0 (deterministic; adder outputs ignored).
- Flag semantics:
  - SUB carry follows two's-complement convention: res_cout=1 means no borrow.
  - Overflow is taken only from add_ovf and is meaningful for signed interpretation.
- Sticky overflow:
  - ovf_sticky set at the EXEC edge of an ADD/SUB with add_ovf=1.
  - Cleared by sticky_clr; set wins if both occur on the same edge.
  - CLEAR/LOAD do not touch ovf_sticky.
- Wrap-around: without saturation, acc wraps modulo 2^WIDTH.
- Reset mid-operation (EXEC or RESP): the operation is discarded, res_valid drops immediately, and all state returns to reset values.
- cmd_data/cmd_op are don't-care whenever cmd_ready=0.

Optional Feature:
- Macro: CLA_ACC_SAT_EN.
- Defined: on ADD/SUB with add_ovf=1, acc is clamped to the signed limit. The sign is taken from add_a[MSB] (the operand sign that caused the overflow):
  - add_a[MSB]=0 gives 0x3FFF (max positive, 15-bit).
  - add_a[MSB]=1 gives 0x4000 (min negative).
  - res_ovf and ovf_sticky still report the overflow; res_cout is unchanged (raw adder carry).
- Undefined: plain wrap; no clamp logic synthesised.

Decomposition:
- Package cla_acc_pkg:
  - WIDTH default.
  - Op encodings OP_CLEAR/OP_LOAD/OP_ADD/OP_SUB.
  - State enum (IDLE/EXEC/RESP).
  - Signed limit constants SMAX/SMIN derived from WIDTH.
- One sub-module is natural: cla_acc_sat, a combinational clamp (sum, ovf, sign → next acc), instantiated only under CLA_ACC_SAT_EN.

Test Plan:
- LOAD 0x0005, then SUB 0x0007 → res_acc=0x7FFE, res_cout=0 (borrow), res_ovf=0; res_valid first high in the cycle after edge N+1.
- LOAD 0x3FFF, ADD 0x0001 → res_ovf=1, ovf_sticky=1, res_cout=0.
  - res_acc=0x4000 without CLA_ACC_SAT_EN.
  - res_acc=0x3FFF with CLA_ACC_SAT_EN.
- LOAD 0x7FFF, ADD 0x0001 → res_acc=0x0000, res_cout=1, res_ovf=0, ovf_sticky unchanged.
- Hold res_ready=0 for 5 cycles in RESP → res_valid and res_acc stable, cmd_ready=0 throughout; a cmd_valid pulse during that window is not accepted.
- Overflowing ADD with sticky_clr pulsed on the same EXEC edge → ovf_sticky=1. Next cycle sticky_clr alone → ovf_sticky=0.
- Assert rst_n=0 during EXEC of ADD 0x0010 → outputs immediately return to reset values, and after release the first LOAD 0x0001 returns res_acc=0x0001.

Source files
------------

// File: rtl/cla_acc_pkg.sv
// cla_acc_pkg: shared width, op encodings, FSM state type and signed limits for cla_acc_seq
package cla_acc_pkg;
    localparam int ACC_WIDTH = 15;
    localparam logic [1:0] OP_CLEAR = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_ADD   = 2'd2;
    localparam logic [1:0] OP_SUB   = 2'd3;
    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/cla_acc_sat.sv
// cla_acc_sat: combinational signed clamp of the adder sum on overflow
//   i_sum  raw adder sum
//   i_ovf  adder signed overflow
//   i_neg  sign of operand A (direction of the overflow)
//   o_sum  clamped sum: max positive or min negative when i_ovf, else i_sum
module cla_acc_sat #(
    parameter int WIDTH = 15
) (
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_ovf,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_sum
);
    logic [WIDTH-1:0] w_lim;
    assign w_lim = i_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign o_sum = i_ovf ? w_lim : i_sum;
endmodule

// File: rtl/cla_acc_seq.sv
// cla_acc_seq: accumulator controller around an external combinational CLA add/sub
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/ready/op/data    command handshake (CLEAR/LOAD/ADD/SUB)
//   add_a/b/mode, add_s/cout/ovf  drive to / result from the external adder
//   res_valid/ready/acc/cout/ovf  result handshake and flags
//   ovf_sticky, sticky_clr     sticky overflow and its clear
// Optional: define CLA_ACC_SAT_EN to clamp acc to the signed limit on overflow.
module cla_acc_seq
    import cla_acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_mode,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    input  logic             add_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_acc,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             ovf_sticky,
    input  logic             sticky_clr
);
    state_t           r_state, w_next;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data, r_acc;
    logic             r_cout, r_ovf, r_sticky;
    logic             w_exec, w_arith;
    logic [WIDTH-1:0] w_sum, w_acc_next;

    assign w_exec  = r_state == EXEC;
    assign w_arith = r_op[1];

`ifdef CLA_ACC_SAT_EN
    cla_acc_sat #(.WIDTH(WIDTH)) u_sat (
        .i_sum (add_s),
        .i_ovf (add_ovf),
        .i_neg (r_acc[WIDTH-1]),
        .o_sum (w_sum)
    );
`else
    assign w_sum = add_s;
`endif

    assign w_acc_next = r_op == OP_CLEAR ? '0 : r_op == OP_LOAD ? r_data : w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = cmd_valid ? EXEC : IDLE;
            EXEC:    w_next = RESP;
            RESP:    w_next = res_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // Outside EXEC the adder sees acc + 0 so its outputs are deterministic.
    always_comb begin
        cmd_ready = r_state == IDLE;
        res_valid = r_state == RESP;
        add_a     = r_acc;
        add_b     = w_exec ? r_data : '0;
        add_mode  = w_exec && r_op == OP_SUB;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_data   <= '0;
            r_acc    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            if (cmd_ready && cmd_valid) begin
                r_op   <= cmd_op;
                r_data <= cmd_data;
            end
            if (w_exec) begin
                r_acc  <= w_acc_next;
                r_cout <= w_arith & add_cout;
                r_ovf  <= w_arith & add_ovf;
            end
            // Set has priority over a simultaneous clear.
            if (w_exec && w_arith && add_ovf) r_sticky <= 1'b1;
            else if (sticky_clr)              r_sticky <= 1'b0;
        end
    end

    assign res_acc    = r_acc;
    assign res_cout   = r_cout;
    assign res_ovf    = r_ovf;
    assign ovf_sticky = r_sticky;
endmodule
